// File: rtl/instruction_prefetch_buffer.sv
// Sequential instruction prefetcher: in-order word requests, a small {pc, inst} queue
// delivered over valid/ready, and redirect flush with draining of stale in-flight responses.
module instruction_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [63:0]            redirect_pc,
    output logic                   imem_req_valid,
    output logic [63:0]            imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_resp_valid,
    input  logic [31:0]            imem_resp_data,
    output logic                   inst_valid,
    output logic [31:0]            inst,
    output logic [63:0]            inst_pc,
    input  logic                   inst_ready,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

    state_t          state_r, state_next;
    logic [63:0]     fetch_pc_r, fetch_pc_next;
    logic [63:0]     resp_pc_r, resp_pc_next;
    logic [PW-1:0]   rd_ptr_r, rd_ptr_next;
    logic [PW-1:0]   wr_ptr_r, wr_ptr_next;
    logic [CW-1:0]   count_r, count_next;
    logic [CW-1:0]   outstanding_r, outstanding_next;
    logic [CW-1:0]   drop_cnt_r, drop_cnt_next;
    logic [63:0]     pc_mem_r [DEPTH];
    logic [31:0]     inst_mem_r [DEPTH];

    logic [CW:0]     credit_used_s;
    logic [CW-1:0]   resp_one_s;
    logic [CW-1:0]   k_s;
    logic [63:0]     redirect_base_s;
    logic            req_fire_s;
    logic            pop_s;
    logic            push_s;

    // Credits cover both queued entries and in-flight requests, so a push never overflows.
    assign credit_used_s   = {1'b0, count_r} + {1'b0, outstanding_r};
    assign imem_req_valid  = !rst && (state_r == FETCH) && !redirect && (credit_used_s < DEPTH_W);
    assign imem_req_addr   = fetch_pc_r;
    assign req_fire_s      = imem_req_valid && imem_req_ready;
    assign inst_valid      = (count_r != {CW{1'b0}});
    assign inst            = inst_mem_r[rd_ptr_r];
    assign inst_pc         = pc_mem_r[rd_ptr_r];
    assign occupancy       = count_r;
    assign pop_s           = inst_valid && inst_ready;
    assign redirect_base_s = redirect_pc & ~64'h3;
    assign resp_one_s      = {{PW{1'b0}}, imem_resp_valid};
    assign k_s             = outstanding_r - resp_one_s;

    // Next-state and datapath update for the FETCH/DRAIN controller.
    always_comb begin
        state_next       = state_r;
        fetch_pc_next    = fetch_pc_r;
        resp_pc_next     = resp_pc_r;
        rd_ptr_next      = rd_ptr_r;
        wr_ptr_next      = wr_ptr_r;
        count_next       = count_r;
        outstanding_next = outstanding_r;
        drop_cnt_next    = drop_cnt_r;
        push_s           = 1'b0;
        case (state_r)
            FETCH: begin
                if (redirect) begin
                    fetch_pc_next    = redirect_base_s;
                    resp_pc_next     = redirect_base_s;
                    rd_ptr_next      = {PW{1'b0}};
                    wr_ptr_next      = {PW{1'b0}};
                    count_next       = {CW{1'b0}};
                    outstanding_next = k_s;
                    drop_cnt_next    = k_s;
                    if (k_s != {CW{1'b0}}) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = FETCH;
                    end
                end else begin
                    push_s = imem_resp_valid;
                    if (req_fire_s) begin
                        fetch_pc_next = fetch_pc_r + 64'd4;
                    end else begin
                        fetch_pc_next = fetch_pc_r;
                    end
                    if (imem_resp_valid) begin
                        resp_pc_next = resp_pc_r + 64'd4;
                        wr_ptr_next  = wr_ptr_r + PW'(1'b1);
                    end else begin
                        resp_pc_next = resp_pc_r;
                        wr_ptr_next  = wr_ptr_r;
                    end
                    if (pop_s) begin
                        rd_ptr_next = rd_ptr_r + PW'(1'b1);
                    end else begin
                        rd_ptr_next = rd_ptr_r;
                    end
                    count_next       = count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
                    outstanding_next = outstanding_r + {{PW{1'b0}}, req_fire_s} - resp_one_s;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_next = redirect_base_s;
                    resp_pc_next  = redirect_base_s;
                end else begin
                    fetch_pc_next = fetch_pc_r;
                    resp_pc_next  = resp_pc_r;
                end
                // Stale responses are counted off; the last one hands control back to FETCH.
                if (imem_resp_valid) begin
                    outstanding_next = outstanding_r - CW'(1'b1);
                    drop_cnt_next    = drop_cnt_r - CW'(1'b1);
                    if (drop_cnt_r == CW'(1'b1)) begin
                        state_next = FETCH;
                    end else begin
                        state_next = DRAIN;
                    end
                end else begin
                    outstanding_next = outstanding_r;
                    drop_cnt_next    = drop_cnt_r;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Controller and pointer/counter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= FETCH;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
        end else begin
            state_r       <= state_next;
            fetch_pc_r    <= fetch_pc_next;
            resp_pc_r     <= resp_pc_next;
            rd_ptr_r      <= rd_ptr_next;
            wr_ptr_r      <= wr_ptr_next;
            count_r       <= count_next;
            outstanding_r <= outstanding_next;
            drop_cnt_r    <= drop_cnt_next;
        end
    end

    // Queue storage, written only by a response accepted while fetching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= 64'h0;
                inst_mem_r[i] <= 32'h0;
            end
        end else if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= resp_pc_r;
            inst_mem_r[wr_ptr_r] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Randomized bench for instruction_prefetch_buffer: a latency-modelled memory plus an
// epoch-based reference of the expected request and instruction streams.
module tb_instruction_prefetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic                   clk, rst, redirect, imem_req_valid, imem_req_ready;
    logic                   imem_resp_valid, inst_valid, inst_ready;
    logic [63:0]            redirect_pc, imem_req_addr, inst_pc;
    logic [31:0]            imem_resp_data, inst;
    logic [$clog2(DEPTH):0] occupancy;

    typedef struct {
        logic [63:0] addr;
        int          due;
        int          ep;
    } req_t;

    req_t        mq[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc, epoch, model_count;
    logic [63:0] exp_pc, exp_req_addr;
    int          lat_min = 1, lat_max = 1, ready_pct = 100, resp_pct = 100;
    logic        iready = 1'b1;
    bit          iready_rand = 1'b0;
    logic [63:0] fire_addr_q[$];
    int          fire_cyc_q[$];
    logic [63:0] pop_pc_q[$];
    int          first_valid_cyc;

    instruction_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic clear_logs();
        fire_addr_q.delete();
        fire_cyc_q.delete();
        pop_pc_q.delete();
        first_valid_cyc = -1;
    endtask

    // One clock cycle: drive inputs, compare against the reference, then advance the model.
    task automatic tick(input logic redir, input logic [63:0] rpc);
        logic exp_req_valid;
        logic stale;
        logic pop_m;
        req_t e;
        redirect        = redir;
        redirect_pc     = rpc;
        imem_req_ready  = ($urandom_range(99) < ready_pct);
        inst_ready      = iready_rand ? 1'($urandom_range(1)) : iready;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (mq.size() > 0) begin
            if (mq[0].due <= cyc && $urandom_range(99) < resp_pct) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_fn(mq[0].addr);
            end
        end
        #1;
        stale = 1'b0;
        foreach (mq[i]) if (mq[i].ep != epoch) stale = 1'b1;
        exp_req_valid = !redir && !stale && (model_count + mq.size() < DEPTH);
        n_tests++;
        if (imem_req_valid !== exp_req_valid) begin
            n_fail++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req_valid);
        end
        if (exp_req_valid) begin
            n_tests++;
            if (imem_req_addr !== exp_req_addr) begin
                n_fail++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_req_addr);
            end
        end
        n_tests++;
        if (occupancy !== 3'(model_count)) begin
            n_fail++;
            $display("FAIL occupancy cyc=%0d got=%0d exp=%0d", cyc, occupancy, model_count);
        end
        n_tests++;
        if (inst_valid !== (model_count != 0)) begin
            n_fail++;
            $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, model_count != 0);
        end
        if (model_count != 0) begin
            n_tests++;
            if (inst_pc !== exp_pc || inst !== mem_fn(exp_pc)) begin
                n_fail++;
                $display("FAIL head cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                         cyc, inst_pc, inst, exp_pc, mem_fn(exp_pc));
            end
        end
        if (inst_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        pop_m = (model_count != 0) && inst_ready;
        if (inst_valid && inst_ready && !redir) pop_pc_q.push_back(inst_pc);
        if (imem_resp_valid) begin
            e = mq.pop_front();
            if (!redir && e.ep == epoch) model_count++;
        end
        if (pop_m && !redir) begin
            model_count--;
            exp_pc = exp_pc + 64'd4;
        end
        if (imem_req_valid && imem_req_ready) begin
            e.addr = imem_req_addr;
            e.due  = cyc + lat_min + int'($urandom_range(lat_max - lat_min));
            e.ep   = epoch;
            mq.push_back(e);
            fire_addr_q.push_back(imem_req_addr);
            fire_cyc_q.push_back(cyc);
            exp_req_addr = exp_req_addr + 64'd4;
        end
        if (redir) begin
            epoch++;
            model_count  = 0;
            exp_pc       = rpc & ~64'h3;
            exp_req_addr = rpc & ~64'h3;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until(input int nfire, input int npop, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (fire_addr_q.size() >= nfire && pop_pc_q.size() >= npop) break;
            tick(1'b0, 64'h0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect = 1'b0; redirect_pc = 64'h0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0; inst_ready = 1'b0;
        #1;
        n_tests++;
        if (inst_valid !== 1'b0 || occupancy !== 3'd0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got v=%b occ=%0d req=%b exp 0/0/0", inst_valid, occupancy, imem_req_valid);
        end
        n_tests++;
        if (imem_req_addr !== RESET_PC || inst !== 32'h0 || inst_pc !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data got addr=%h inst=%h pc=%h", imem_req_addr, inst, inst_pc);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        model_count = 0; epoch = 0; cyc = 0;
        exp_pc = RESET_PC; exp_req_addr = RESET_PC;
        clear_logs();
    endtask

    task automatic test_stream();
        test_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100; resp_pct = 100; iready = 1'b1; iready_rand = 1'b0;
        repeat (20) tick(1'b0, 64'h0);
        n_tests++;
        if (fire_cyc_q.size() < 3) begin
            n_fail++;
            $display("FAIL stream_reqs got=%0d requests need>=3", fire_cyc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (fire_cyc_q[i] !== i || fire_addr_q[i] !== 64'(i * 4)) begin
                    n_fail++;
                    $display("FAIL stream_req%0d got cyc=%0d addr=%h exp cyc=%0d addr=%h",
                             i, fire_cyc_q[i], fire_addr_q[i], i, 64'(i * 4));
                end
            end
        end
        n_tests++;
        if (first_valid_cyc !== 2) begin
            n_fail++;
            $display("FAIL stream_latency got=%0d exp=2", first_valid_cyc);
        end
        n_tests++;
        if (pop_pc_q.size() !== 18) begin
            n_fail++;
            $display("FAIL stream_rate got=%0d pops exp=18", pop_pc_q.size());
        end
    endtask

    task automatic test_stall();
        test_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100; resp_pct = 100; iready = 1'b0; iready_rand = 1'b0;
        repeat (10) tick(1'b0, 64'h0);
        #1;
        n_tests++;
        if (occupancy !== 3'd4 || imem_req_valid !== 1'b0 || inst_pc !== 64'h0 || inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_full got occ=%0d req=%b pc=%h v=%b exp 4/0/0/1",
                     occupancy, imem_req_valid, inst_pc, inst_valid);
        end
        iready = 1'b1;
        clear_logs();
        run_until(1, 5, 30);
        n_tests++;
        if (pop_pc_q.size() < 5 || fire_addr_q.size() < 1) begin
            n_fail++;
            $display("FAIL stall_timeout got pops=%0d reqs=%0d", pop_pc_q.size(), fire_addr_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (pop_pc_q[i] !== 64'(i * 4)) begin
                    n_fail++;
                    $display("FAIL stall_order%0d got=%h exp=%h", i, pop_pc_q[i], 64'(i * 4));
                end
            end
            n_tests++;
            if (fire_addr_q[0] !== 64'h10) begin
                n_fail++;
                $display("FAIL stall_resume got=%h exp=%h", fire_addr_q[0], 64'h10);
            end
        end
    endtask

    task automatic check_restart(input string tag, input int exp_cyc, input logic [63:0] exp_addr);
        run_until(1, 1, 40);
        n_tests++;
        if (fire_addr_q.size() < 1 || pop_pc_q.size() < 1) begin
            n_fail++;
            $display("FAIL %s_timeout got reqs=%0d pops=%0d", tag, fire_addr_q.size(), pop_pc_q.size());
        end else begin
            n_tests++;
            if (fire_cyc_q[0] !== exp_cyc || fire_addr_q[0] !== exp_addr) begin
                n_fail++;
                $display("FAIL %s_req got cyc=%0d addr=%h exp cyc=%0d addr=%h",
                         tag, fire_cyc_q[0], fire_addr_q[0], exp_cyc, exp_addr);
            end
            n_tests++;
            if (pop_pc_q[0] !== exp_addr) begin
                n_fail++;
                $display("FAIL %s_pop got=%h exp=%h", tag, pop_pc_q[0], exp_addr);
            end
        end
    endtask

    task automatic test_redirect_drain();
        test_reset();
        lat_min = 3; lat_max = 3; ready_pct = 100; resp_pct = 100; iready = 1'b1; iready_rand = 1'b0;
        repeat (2) tick(1'b0, 64'h0);
        ready_pct = 0;
        tick(1'b1, 64'h100);
        ready_pct = 100;
        clear_logs();
        check_restart("drain", 5, 64'h100);
    endtask

    task automatic test_redirect_same_cycle();
        test_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100; resp_pct = 100; iready = 1'b1; iready_rand = 1'b0;
        tick(1'b0, 64'h0);
        tick(1'b1, 64'h300);
        clear_logs();
        check_restart("samecyc", 2, 64'h300);
    endtask

    task automatic test_double_redirect();
        test_reset();
        lat_min = 4; lat_max = 4; ready_pct = 100; resp_pct = 100; iready = 1'b1; iready_rand = 1'b0;
        repeat (3) tick(1'b0, 64'h0);
        ready_pct = 0;
        tick(1'b1, 64'h100);
        ready_pct = 100;
        tick(1'b0, 64'h0);
        tick(1'b1, 64'h200);
        clear_logs();
        check_restart("double", 7, 64'h200);
    endtask

    task automatic test_wrap();
        test_reset();
        lat_min = 1; lat_max = 3; ready_pct = 100; resp_pct = 100; iready = 1'b1; iready_rand = 1'b0;
        repeat (8) tick(1'b0, 64'h0);
        tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        clear_logs();
        run_until(2, 2, 60);
        n_tests++;
        if (fire_addr_q.size() < 2 || pop_pc_q.size() < 2) begin
            n_fail++;
            $display("FAIL wrap_timeout got reqs=%0d pops=%0d", fire_addr_q.size(), pop_pc_q.size());
        end else begin
            n_tests++;
            if (fire_addr_q[0] !== 64'hFFFF_FFFF_FFFF_FFFC || fire_addr_q[1] !== 64'h0) begin
                n_fail++;
                $display("FAIL wrap_req got=%h,%h exp=fffffffffffffffc,0", fire_addr_q[0], fire_addr_q[1]);
            end
            n_tests++;
            if (pop_pc_q[0] !== 64'hFFFF_FFFF_FFFF_FFFC || pop_pc_q[1] !== 64'h0) begin
                n_fail++;
                $display("FAIL wrap_pop got=%h,%h exp=fffffffffffffffc,0", pop_pc_q[0], pop_pc_q[1]);
            end
        end
        tick(1'b1, 64'h103);
        clear_logs();
        run_until(1, 1, 60);
        n_tests++;
        if (fire_addr_q.size() < 1 || pop_pc_q.size() < 1) begin
            n_fail++;
            $display("FAIL align_timeout got reqs=%0d pops=%0d", fire_addr_q.size(), pop_pc_q.size());
        end else if (fire_addr_q[0] !== 64'h100 || pop_pc_q[0] !== 64'h100) begin
            n_fail++;
            $display("FAIL align got req=%h pop=%h exp=100", fire_addr_q[0], pop_pc_q[0]);
        end
    endtask

    task automatic random_phase(input int n);
        logic [63:0] tgt;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(2))
                0:       tgt = {$urandom, $urandom};
                1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
                default: tgt = 64'($urandom_range(4095));
            endcase
            tick($urandom_range(99) < 3, tgt);
        end
    endtask

    task automatic test_random();
        test_reset();
        lat_min = 1; lat_max = 4; ready_pct = 70; resp_pct = 75; iready_rand = 1'b1;
        random_phase(1500);
        test_reset();
        random_phase(1500);
        iready_rand = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        #2;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_redirect_same_cycle();
        test_double_redirect();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_prefetch_buffer.md
# instruction_prefetch_buffer

Sequential instruction prefetcher sitting directly upstream of the instruction fetch stage. It issues in-order word requests to a multi-cycle instruction memory, queues returned instructions with their PCs in a small FIFO, and presents them to the fetch stage over a valid/ready handshake. A branch redirect from the execute stage flushes the queue and discards in-flight responses.

## Interface
- DEPTH, 4, FIFO entries and maximum requests in flight combined; power of two, ≥2
- RESET_PC, 64'h0, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- redirect  in  1  taken branch; restart fetch at redirect_pc
- redirect_pc  in  64  redirect target; bits [1:0] forced to 0 internally
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  64  word address of request
- imem_req_ready  in  1  memory accepts request this cycle
- imem_resp_valid  in  1  response data valid; one per accepted request, in order, ≥1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  head entry valid
- inst  out  32  head instruction
- inst_pc  out  64  PC of head instruction
- inst_ready  in  1  fetch stage consumes head (low = stall, driven from PC_write)
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count

## Operation
- Registers: fetch_pc (next request address), resp_pc (PC of oldest in-flight request), FIFO storage {pc, inst}, rd_ptr, wr_ptr, count, outstanding, drop_cnt, state.
- States: FETCH, DRAIN.
- FETCH: imem_req_valid = !redirect && (count + outstanding < DEPTH); imem_req_addr = fetch_pc. Request fire (valid & ready): fetch_pc += 4, outstanding += 1.
- FETCH response: push {resp_pc, imem_resp_data} at wr_ptr, resp_pc += 4, outstanding -= 1. Space is guaranteed by the credit rule; no overflow check needed.
- Pop: inst_valid & inst_ready advances rd_ptr and decrements count. Simultaneous push and pop leaves count unchanged.
- Redirect in FETCH: FIFO cleared (count=0, rd_ptr=wr_ptr=0), fetch_pc = resp_pc = redirect_pc. No request is issued in a redirect cycle. Let k = outstanding − imem_resp_valid. Any response arriving in that cycle is discarded. If k>0, drop_cnt = k and the next state is DRAIN; otherwise stay in FETCH.
- DRAIN: imem_req_valid = 0. Every response is discarded and decrements drop_cnt and outstanding. A response with drop_cnt==1 returns the block to FETCH next cycle.
- Redirect in DRAIN: fetch_pc = resp_pc = redirect_pc and the FIFO stays empty. drop_cnt and outstanding are decremented only by a response arriving that cycle. The block stays in DRAIN unless that response was the last.
- Arithmetic: PCs are 64-bit, wrapping modulo 2^64. outstanding and count never exceed DEPTH.

## Timing
- Reset (async assert): count=0, outstanding=0, drop_cnt=0, rd_ptr=wr_ptr=0, state=FETCH, fetch_pc=resp_pc=RESET_PC. Outputs: inst_valid=0, occupancy=0, imem_req_valid=0 while rst is high, imem_req_addr=RESET_PC, inst=0, inst_pc=0.
- Cycle 0 after reset release: imem_req_valid=1 at RESET_PC.
- Best-case latency is 2 cycles from request acceptance to inst_valid: response at cycle 1, registered push, inst_valid=1 at cycle 2.
- inst, inst_pc and inst_valid are registered FIFO head values; there is no combinational path from imem_resp to inst.
- Redirect at cycle N:
  - inst_valid=0 from cycle N+1.
  - First request at redirect_pc is issued at N+1 if k=0.
  - Otherwise it is issued the cycle after the last discarded response.
- Reset mid-operation clears all state immediately. Responses to pre-reset requests are the memory's responsibility and must not arrive.
- inst_ready low holds the head stable. Requests stop once count + outstanding == DEPTH.

## Test plan
- Reset release, memory with 1-cycle latency, inst_ready=1 → requests at 0x0, 0x4, 0x8… on consecutive cycles. inst_valid at cycle 2 with inst_pc=0x0, then one instruction per cycle, PCs incrementing by 4.
- inst_ready=0 for 10 cycles, DEPTH=4 → occupancy=4, imem_req_valid=0, and the head holds inst_pc=0x0. Raising inst_ready drains 0x0–0xC in order, then prefetch resumes at 0x10.
- Memory with 3-cycle latency and 2 outstanding requests; redirect to 0x100 → both stale responses are dropped (state DRAIN for 2 responses). The first request is 0x100, and the first inst_pc after the flush is 0x100.
- Redirect in the same cycle as a response, with outstanding=1 → response discarded, no DRAIN, request to redirect_pc on the next cycle.
- Second redirect to 0x200 during DRAIN → the remaining stale responses are dropped and fetch restarts at 0x200, not 0x100.
- redirect_pc=0xFFFFFFFFFFFFFFFC → the next requests are 0xFFFF…FFFC and then 0x0 (wrap). redirect_pc=0x103 is fetched as 0x100.
